pio_clkdiv_bank: RTL and testbench

Parametrised fractional clock-enable generator for a multi-state-machine PIO. Each of `N_CH` channels produces a one-`clk` `penable` strobe at an average rate of `clk / (INT + FRAC/2^FRAC_W)`. It replaces the single-channel integer divider. It sits between the PIO register file, which supplies the divisor, enable and restart per state machine, and the state-machine array, which consumes `penable`.

---
 rtl/pio_clkdiv_bank.sv | 82 ++++++++
 tb/tb_pio_clkdiv_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_clkdiv_bank.sv
// Bank of N_CH fractional clock-enable dividers: penable[i] averages clk / (INT + FRAC/2^FRAC_W).
// Optional per-channel hold input is compiled in only when PIO_CLKDIV_STALL_EN is defined.
module pio_clkdiv_bank #(
    parameter int N_CH   = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         cfg_we,
    input  logic [INT_W+FRAC_W-1:0] cfg_div,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH-1:0]         restart,
    input  logic [N_CH-1:0]         stall,
    output logic [N_CH-1:0]         penable
);

    localparam int CNT_W = INT_W + 1;

    logic [INT_W-1:0]  r_div_int  [N_CH];
    logic [FRAC_W-1:0] r_div_frac [N_CH];
    logic [CNT_W-1:0]  r_cnt      [N_CH];
    logic [FRAC_W-1:0] r_acc      [N_CH];
    logic [N_CH-1:0]   r_penable;

    logic [FRAC_W:0]   w_acc_sum  [N_CH];
    logic [CNT_W-1:0]  w_int_eff  [N_CH];
    logic [CNT_W-1:0]  w_reload   [N_CH];

`ifndef PIO_CLKDIV_STALL_EN
    logic w_unused_stall;
    assign w_unused_stall = ^stall;
`endif

    // NOTE: every element is written on every pass, so no latch can be inferred here.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_acc_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_div_frac[i]};
            // A zero integer field means the full 2^INT_W range.
            w_int_eff[i] = (r_div_int[i] == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, r_div_int[i]};
            w_reload[i]  = w_int_eff[i] - CNT_W'(1) + CNT_W'(w_acc_sum[i][FRAC_W]);
        end
    end

    // NOTE: state uses non-blocking assignments so every channel sees pre-edge values.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!reset) begin
                // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they take reset.
                r_div_int[i]  <= INT_W'(1);
                r_div_frac[i] <= '0;
                r_cnt[i]      <= '0;
                r_acc[i]      <= '0;
                r_penable[i]  <= 1'b0;
            end else begin
                if (cfg_we[i]) begin
                    r_div_int[i]  <= cfg_div[INT_W+FRAC_W-1:FRAC_W];
                    r_div_frac[i] <= cfg_div[FRAC_W-1:0];
                end
                if (!ch_en[i] || restart[i]) begin
                    r_cnt[i]     <= '0;
                    r_acc[i]     <= '0;
                    r_penable[i] <= 1'b0;
`ifdef PIO_CLKDIV_STALL_EN
                end else if (stall[i]) begin
                    r_penable[i] <= 1'b0;
`endif
                end else if (r_cnt[i] == '0) begin
                    r_penable[i] <= 1'b1;
                    r_acc[i]     <= w_acc_sum[i][FRAC_W-1:0];
                    r_cnt[i]     <= w_reload[i];
                end else begin
                    r_cnt[i]     <= r_cnt[i] - CNT_W'(1);
                    r_penable[i] <= 1'b0;
                end
            end
        end
    end

    assign penable = r_penable;

endmodule

// File: tb/tb_pio_clkdiv_bank.sv
// Scoreboard bench for pio_clkdiv_bank: an absolute-time strobe model predicts penable every cycle.
// Directed scenarios cover divide-by-1, integer, fractional, full-range, phase-align and stall cases.
module tb_pio_clkdiv_bank;

    localparam int N_CH   = 4;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 8;
    localparam int FRAC_MOD = 1 << FRAC_W;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [N_CH-1:0]         cfg_we = '0;
    logic [INT_W+FRAC_W-1:0] cfg_div = '0;
    logic [N_CH-1:0]         ch_en = '0;
    logic [N_CH-1:0]         restart = '0;
    logic [N_CH-1:0]         stall = '0;
    logic [N_CH-1:0]         penable;

    pio_clkdiv_bank #(.N_CH(N_CH), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .ch_en(ch_en), .restart(restart), .stall(stall), .penable(penable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel knows the absolute cycle of its next strobe.
    longint          cyc = 0;
    int unsigned     m_div_int  [N_CH];
    int unsigned     m_div_frac [N_CH];
    int unsigned     m_phase    [N_CH];
    longint          m_next     [N_CH];
    logic [N_CH-1:0] exp_q [$];

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            m_div_int[c] = 1; m_div_frac[c] = 0; m_phase[c] = 0; m_next[c] = 1;
        end
    end

    always @(posedge clk) begin
        logic [N_CH-1:0] e;
        int unsigned     period;
        cyc++;
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!reset) begin
                m_div_int[c] = 1; m_div_frac[c] = 0; m_phase[c] = 0; m_next[c] = cyc + 1;
            end else begin
                if (!ch_en[c] || restart[c]) begin
                    m_phase[c] = 0;
                    m_next[c]  = cyc + 1;
`ifdef PIO_CLKDIV_STALL_EN
                end else if (stall[c]) begin
                    m_next[c] = m_next[c] + 1;
`endif
                end else if (cyc == m_next[c]) begin
                    e[c]   = 1'b1;
                    period = (m_div_int[c] == 0) ? (1 << INT_W) : m_div_int[c];
                    m_phase[c] = m_phase[c] + m_div_frac[c];
                    if (m_phase[c] >= FRAC_MOD) begin
                        m_phase[c] = m_phase[c] - FRAC_MOD;
                        period = period + 1;
                    end
                    m_next[c] = cyc + period;
                end
                if (cfg_we[c]) begin
                    m_div_int[c]  = cfg_div[INT_W+FRAC_W-1:FRAC_W];
                    m_div_frac[c] = cfg_div[FRAC_W-1:0];
                end
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compares every cycle and records strobe statistics for directed checks.
    longint mcyc = 0;
    longint last_strobe [N_CH];
    longint interval    [N_CH];
    int     strobe_cnt  [N_CH];

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            last_strobe[c] = -1; interval[c] = 0; strobe_cnt[c] = 0;
        end
    end

    always @(negedge clk) begin
        mcyc++;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            check("penable", 64'(penable), 64'(exp_q.pop_front()));
        end
        for (int c = 0; c < N_CH; c++) begin
            if (penable[c] === 1'b1) begin
                if (last_strobe[c] >= 0) interval[c] = mcyc - last_strobe[c];
                last_strobe[c] = mcyc;
                strobe_cnt[c]++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_strobes(input int c, input int target, input int bound, input string name);
        int k;
        k = 0;
        while (strobe_cnt[c] < target && k < bound) begin
            step(1);
            k++;
        end
        check(name, 64'(strobe_cnt[c] >= target), 64'd1);
    endtask

    initial begin
        int n;
        int base;
        logic [1:0] ev;

        step(2);
        reset = 1'b1;
        step(2);
        check("reset_pen", 64'(penable), 64'd0);

        // Divide-by-1 on ch0.
        ch_en = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check("div1", 64'(penable), 64'b0001);
        end

        // Integer divide by 3 on ch1.
        cfg_we = 4'b0010; cfg_div = 24'h000300;
        step(1);
        cfg_we = '0; ch_en[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check("ch1_div3", 64'(penable[1]), 64'((k - 1) % 3 == 0));
        end

        // Fractional 2.5 on ch2: 8 strobes in 20 cycles.
        cfg_we = 4'b0100; cfg_div = 24'h000280;
        step(1);
        cfg_we = '0; ch_en[2] = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (penable[2]) n++;
        end
        check("ch2_frac_count", 64'(n), 64'd8);

        // Phase alignment of ch0/ch1 at divisor 4.
        ch_en[1:0] = 2'b00; cfg_we = 4'b0011; cfg_div = 24'h000400;
        step(1);
        cfg_we = '0; ch_en[0] = 1'b1;
        step(2);
        ch_en[1] = 1'b1;
        step(3);
        restart = 4'b0011;
        for (int k = 1; k <= 13; k++) begin
            step(1);
            if (k == 1) restart = '0;
            ev = (k >= 2 && (k - 2) % 4 == 0) ? 2'b11 : 2'b00;
            check("align", 64'(penable[1:0]), 64'(ev));
        end

        // Full-range divisor on ch3.
        cfg_we = 4'b1000; cfg_div = 24'h000000;
        step(1);
        cfg_we = '0; ch_en[3] = 1'b1;
        wait_strobes(3, 2, 70000, "ch3_wait");
        check("ch3_interval", 64'(interval[3]), 64'd65536);

        // Stall mid-period on ch0 at divisor 5, with write and restart in the same cycle.
        cfg_we = 4'b0001; cfg_div = 24'h000500; restart = 4'b0001;
        step(1);
        cfg_we = '0; restart = '0;
        base = strobe_cnt[0];
        wait_strobes(0, base + 1, 20, "stall_first");
        step(2);
        stall = 4'b0001;
        step(7);
        stall = '0;
        wait_strobes(0, base + 2, 40, "stall_second");
`ifdef PIO_CLKDIV_STALL_EN
        check("stall_interval", 64'(interval[0]), 64'd12);
`else
        check("stall_interval", 64'(interval[0]), 64'd5);
`endif

        // Randomized traffic checked by the scoreboard.
        ch_en = 4'hF;
        for (int k = 0; k < 3000; k++) begin
            cfg_we  = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
            cfg_div = {16'(($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 5)), 8'($urandom)};
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
            restart = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            stall   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            reset   = ($urandom_range(0, 499) != 0);
            step(1);
        end
        cfg_we = '0; restart = '0; stall = '0; reset = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
